set_assoc_cache_controller: RTL and testbench

Control FSM for the configurable N-way set-associative, write-back/write-allocate cache. It is the multi-way, multi-beat successor of the direct-mapped controller. It sits between the CPU request port, the tag/valid/dirty arrays and the main-memory valid/ready handshake. It selects a victim way (first invalid, else round-robin), writes back dirty lines and refills lines as multi-beat bursts.

---
 rtl/set_assoc_cache_controller.sv | 178 +++++++++++++++++
 tb/tb_set_assoc_cache_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache_controller.sv
// Control FSM for an N-way set-associative write-back/write-allocate cache.
// Picks a victim way, bursts dirty lines out and refills lines beat by beat.
module set_assoc_cache_controller #(
    parameter  int NUM_WAYS       = 2,
    parameter  int BEATS_PER_LINE = 4,
    localparam int BW = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1,
    localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_type,
    input  logic [NUM_WAYS-1:0] hit_way,
    input  logic [NUM_WAYS-1:0] valid_bits,
    input  logic [NUM_WAYS-1:0] dirty_bits,
    input  logic                req_ready_mem,
    output logic                req_valid_mem,
    input  logic                resp_valid_mem,
    output logic                resp_ready_mem,
    output logic                read_en_mem,
    output logic                write_en_mem,
    output logic [BW-1:0]       beat_idx,
    output logic [NUM_WAYS-1:0] way_sel,
    output logic                read_en_cache,
    output logic                write_en_cache,
    output logic                refill,
    output logic                done_cache,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        WAIT_ALLOCATE,
        ALLOC_REQ,
        ALLOC_RESP,
        REFILL_DONE
    } state_t;

    state_t              state, next_state;
    logic                req_type_q;
    logic [NUM_WAYS-1:0] way_q;
    logic [BW-1:0]       beat_q;
    logic [WW-1:0]       rr_ptr;
    logic                from_rr_q;

    logic [NUM_WAYS-1:0] hit_sel;
    logic [NUM_WAYS-1:0] victim;
    logic                victim_from_rr;
    logic                victim_dirty;
    logic                last_beat;

    // Lowest-index priority for both hit selection and invalid-way victim search.
    always_comb begin
        hit_sel        = '0;
        victim         = '0;
        victim_from_rr = &valid_bits;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hit_way[i]) begin
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
            end
            if (!valid_bits[i]) begin
                victim    = '0;
                victim[i] = 1'b1;
            end
        end
        if (victim_from_rr) begin
            victim         = '0;
            victim[rr_ptr] = 1'b1;
        end
        victim_dirty = |(victim & valid_bits & dirty_bits);
    end

    assign last_beat = (beat_q == BW'(BEATS_PER_LINE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:          if (req_valid) next_state = COMPARE;
            COMPARE: begin
                if (|hit_way)          next_state = IDLE;
                else if (victim_dirty) next_state = WRITE_BACK;
                else                   next_state = ALLOC_REQ;
            end
            WRITE_BACK:    if (req_ready_mem && last_beat) next_state = WAIT_ALLOCATE;
            WAIT_ALLOCATE: next_state = ALLOC_REQ;
            ALLOC_REQ:     if (req_ready_mem) next_state = ALLOC_RESP;
            ALLOC_RESP:    if (resp_valid_mem && last_beat) next_state = REFILL_DONE;
            REFILL_DONE:   next_state = IDLE;
            default:       next_state = IDLE;
        endcase
    end

    // Request type, selected way, burst beat counter and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_type_q <= 1'b0;
            way_q      <= '0;
            beat_q     <= '0;
            rr_ptr     <= '0;
            from_rr_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) req_type_q <= req_type;
                COMPARE: begin
                    beat_q <= '0;
                    if (|hit_way) begin
                        way_q <= hit_sel;
                    end else begin
                        way_q     <= victim;
                        from_rr_q <= victim_from_rr;
                    end
                end
                WRITE_BACK: if (req_ready_mem) beat_q <= last_beat ? '0 : beat_q + BW'(1);
                ALLOC_RESP: if (resp_valid_mem) beat_q <= last_beat ? '0 : beat_q + BW'(1);
                REFILL_DONE: begin
                    if (from_rr_q) rr_ptr <= (rr_ptr == WW'(NUM_WAYS - 1)) ? '0 : rr_ptr + WW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_valid_mem  = 1'b0;
        resp_ready_mem = 1'b0;
        read_en_mem    = 1'b0;
        write_en_mem   = 1'b0;
        read_en_cache  = 1'b0;
        write_en_cache = 1'b0;
        refill         = 1'b0;
        done_cache     = 1'b0;
        way_sel        = way_q;
        beat_idx       = beat_q;
        busy           = (state != IDLE);
        case (state)
            COMPARE: begin
                if (|hit_way) begin
                    way_sel        = hit_sel;
                    done_cache     = 1'b1;
                    read_en_cache  = ~req_type_q;
                    write_en_cache = req_type_q;
                end
            end
            WRITE_BACK: begin
                req_valid_mem = 1'b1;
                write_en_mem  = req_ready_mem;
            end
            ALLOC_REQ: begin
                req_valid_mem = 1'b1;
                read_en_mem   = req_ready_mem;
            end
            ALLOC_RESP: begin
                resp_ready_mem = 1'b1;
                write_en_cache = resp_valid_mem;
            end
            REFILL_DONE: begin
                refill         = 1'b1;
                done_cache     = 1'b1;
                write_en_cache = req_type_q;
                read_en_cache  = ~req_type_q;
            end
            default: ;
        endcase
        if (NUM_WAYS == 1) way_sel = '1;
    end

endmodule

// File: tb/tb_set_assoc_cache_controller.sv
// Directed scoreboard bench for set_assoc_cache_controller (4 ways, 4 beats per line).
module tb_set_assoc_cache_controller;

    localparam int NW = 4;
    localparam int B  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_type;
    logic [NW-1:0] hit_way, valid_bits, dirty_bits;
    logic          req_ready_mem, req_valid_mem;
    logic          resp_valid_mem, resp_ready_mem;
    logic          read_en_mem, write_en_mem;
    logic [1:0]    beat_idx;
    logic [NW-1:0] way_sel;
    logic          read_en_cache, write_en_cache, refill, done_cache, busy;

    typedef struct packed {
        logic       wem;
        logic       rem;
        logic       wec;
        logic       rec;
        logic       done;
        logic       refill;
        logic [3:0] way;
        logic [1:0] beat;
    } ev_t;

    ev_t        exp_q[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [1:0] model_rr = 2'd0;

    set_assoc_cache_controller #(.NUM_WAYS(NW), .BEATS_PER_LINE(B)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_type(req_type),
        .hit_way(hit_way), .valid_bits(valid_bits), .dirty_bits(dirty_bits),
        .req_ready_mem(req_ready_mem), .req_valid_mem(req_valid_mem),
        .resp_valid_mem(resp_valid_mem), .resp_ready_mem(resp_ready_mem),
        .read_en_mem(read_en_mem), .write_en_mem(write_en_mem),
        .beat_idx(beat_idx), .way_sel(way_sel),
        .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
        .refill(refill), .done_cache(done_cache), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] all_outputs();
        return {req_valid_mem, resp_ready_mem, read_en_mem, write_en_mem, beat_idx,
                way_sel, read_en_cache, write_en_cache, refill, done_cache, busy};
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected event stream of one request, in order.
    task automatic push_expected(input logic typ, input logic [3:0] hit,
                                 input logic [3:0] valid, input logic [3:0] dirty);
        logic [3:0] way;
        logic       from_rr;
        ev_t        e;
        way = '0;
        if (|hit) begin
            for (int i = NW - 1; i >= 0; i--) if (hit[i]) begin way = '0; way[i] = 1'b1; end
            e = '0; e.wec = typ; e.rec = ~typ; e.done = 1'b1; e.way = way;
            exp_q.push_back(e);
        end else begin
            from_rr = 1'b1;
            for (int i = NW - 1; i >= 0; i--)
                if (!valid[i]) begin way = '0; way[i] = 1'b1; from_rr = 1'b0; end
            if (from_rr) begin way = '0; way[model_rr] = 1'b1; end
            if (|(way & valid & dirty)) begin
                for (int b = 0; b < B; b++) begin
                    e = '0; e.wem = 1'b1; e.way = way; e.beat = 2'(b);
                    exp_q.push_back(e);
                end
            end
            e = '0; e.rem = 1'b1; e.way = way;
            exp_q.push_back(e);
            for (int b = 0; b < B; b++) begin
                e = '0; e.wec = 1'b1; e.way = way; e.beat = 2'(b);
                exp_q.push_back(e);
            end
            e = '0; e.wec = typ; e.rec = ~typ; e.done = 1'b1; e.refill = 1'b1; e.way = way;
            exp_q.push_back(e);
            if (from_rr) model_rr = model_rr + 2'd1;
        end
    endtask

    task automatic sample_events(input string name);
        ev_t obs;
        ev_t e;
        obs = '0;
        obs.wem = write_en_mem; obs.rem = read_en_mem; obs.wec = write_en_cache;
        obs.rec = read_en_cache; obs.done = done_cache; obs.refill = refill;
        if (obs.wem | obs.rem | obs.wec | obs.rec | obs.done | obs.refill) begin
            obs.way  = way_sel;
            obs.beat = beat_idx;
            if (exp_q.size() == 0) begin
                check_output({name, " unexpected event"}, 32'(obs), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_output({name, " event"}, 32'(obs), 32'(e));
            end
        end
    endtask

    // One CPU request; entered and left at posedge+1. rst_cycle >= 0 aborts with reset there.
    task automatic apply_stimulus(input string name, input logic typ, input logic [3:0] hit,
                                  input logic [3:0] valid, input logic [3:0] dirty,
                                  input logic [63:0] ready_mask, input logic [63:0] resp_mask,
                                  input int exp_done, input int rst_cycle);
        int done_c;
        done_c = -1;
        push_expected(typ, hit, valid, dirty);
        req_valid  = 1'b1;
        req_type   = typ;
        hit_way    = hit;
        valid_bits = valid;
        dirty_bits = dirty;
        for (int c = 0; c < 64 && done_c < 0; c++) begin
            req_ready_mem  = ready_mask[c];
            resp_valid_mem = resp_mask[c];
            if (c == rst_cycle) begin
                rst = 1'b1;
                #1;
                check_output({name, " outputs during reset"}, 32'(all_outputs()), 32'd0);
                exp_q.delete();
                model_rr = 2'd0;
                @(posedge clk); #1;
                rst       = 1'b0;
                req_valid = 1'b0;
                #1;
                check_output({name, " outputs after reset"}, 32'(all_outputs()), 32'd0);
                @(posedge clk); #1;
                return;
            end
            #1;
            sample_events(name);
            if (c == 1) check_output({name, " busy"}, 32'(busy), 32'd1);
            if (done_cache) done_c = c;
            @(posedge clk); #1;
        end
        req_valid      = 1'b0;
        req_ready_mem  = 1'b0;
        resp_valid_mem = 1'b0;
        check_output({name, " done cycle"}, 32'(done_c), 32'(exp_done));
        check_output({name, " leftover events"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        #1;
        check_output({name, " idle after done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_type       = 1'b0;
        hit_way        = '0;
        valid_bits     = '0;
        dirty_bits     = '0;
        req_ready_mem  = 1'b0;
        resp_valid_mem = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_output("reset outputs", 32'(all_outputs()), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_output("outputs after reset release", 32'(all_outputs()), 32'd0);

        $display("[TB] hits");
        apply_stimulus("read hit",        1'b0, 4'b0100, 4'b1111, 4'b0000, '1, '1, 1, -1);
        apply_stimulus("multi-hot write", 1'b1, 4'b1010, 4'b1111, 4'b0000, '1, '1, 1, -1);

        $display("[TB] misses");
        apply_stimulus("write miss invalid way", 1'b1, 4'b0000, 4'b1011, 4'b0000, '1, '1, B + 3, -1);
        apply_stimulus("rr miss 0", 1'b0, 4'b0000, 4'b1111, 4'b0000, '1, '1, B + 3, -1);
        apply_stimulus("rr miss 1", 1'b0, 4'b0000, 4'b1111, 4'b0000, '1, '1, B + 3, -1);
        // write-back B beats from cycle 2, one gap cycle, one request cycle, B refill beats
        apply_stimulus("dirty miss rr 2", 1'b0, 4'b0000, 4'b1111, 4'b1111, '1, '1, 2 + B + 1 + 1 + B, -1);
        apply_stimulus("rr miss 3", 1'b0, 4'b0000, 4'b1111, 4'b0000, '1, '1, B + 3, -1);
        apply_stimulus("rr wrap",   1'b0, 4'b0000, 4'b1111, 4'b0000, '1, '1, B + 3, -1);

        $display("[TB] stalls");
        // 3 write-back stall cycles and 3 response gaps on top of the dirty-miss latency
        apply_stimulus("stalled dirty write", 1'b1, 4'b0000, 4'b1111, 4'b1111,
                       64'hFFFF_FFFF_FFFF_FFC7, 64'h0000_0000_0002_A800, 2 + B + 1 + 1 + B + 6, -1);

        $display("[TB] reset mid-burst");
        apply_stimulus("reset in refill", 1'b0, 4'b0000, 4'b0111, 4'b0000, '1, '1, 0, 5);
        apply_stimulus("hit after reset", 1'b0, 4'b0001, 4'b1111, 4'b0000, '1, '1, 1, -1);
        apply_stimulus("rr after reset",  1'b1, 4'b0000, 4'b1111, 4'b0000, '1, '1, B + 3, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
